sh7034_macw_seq: RTL and testbench

Operand sequencer for the SH7034 MAC.W @Rm+,@Rn+ instruction. It sits between the execution pipeline and the multiply/accumulate unit. It performs the two halfword memory reads and posts the post-incremented Rm/Rn values back to the register file. It then delivers each operand to the multiplier over the MAC write port, in the order that arms the accumulate: MB first, MA last.

---
 rtl/sh7034_macw_seq.sv | 114 +++++++++++
 tb/tb_sh7034_macw_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sh7034_macw_seq.sv
// sh7034_macw_seq: MAC.W @Rm+,@Rn+ operand sequencer; reads both halfwords, posts Rm/Rn
// writebacks and feeds MB then MA to the multiplier write port.
module sh7034_macw_seq (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic        START,
  input  logic        S_BIT,
  input  logic        SAME_REG,
  input  logic [31:0] RM_VAL,
  input  logic [31:0] RN_VAL,
  output logic [27:0] MEM_A,
  output logic [3:0]  MEM_BA,
  output logic        MEM_REQ,
  input  logic [31:0] MEM_DI,
  input  logic        MEM_BUSY,
  output logic [31:0] RM_NEW,
  output logic        RM_WE,
  output logic [31:0] RN_NEW,
  output logic        RN_WE,
  output logic [1:0]  MAC_SEL,
  output logic [3:0]  MAC_OP,
  output logic        MAC_S,
  output logic        MAC_WE,
  output logic [27:0] MAC_A,
  output logic [31:0] MAC_DI,
  output logic        BUSY,
  input  logic        STS_REQ,
  output logic        STALL,
  output logic        ADDR_ERR
);
  typedef enum logic [2:0] {IDLE, RD_N, WB, RD_M, WA} state_t;
  state_t state_q, state_d;
  logic [31:0] rm_q, rm_d, rn_q, rn_d, dbuf_q, dbuf_d;
  logic [27:0] addr_q, addr_d, m_addr;
  logic s_q, s_d, same_q, same_d, post_q, post_d;
  logic rd_n, rd_m, mac_wr, unused;
  assign unused = CE_F;
  // with SAME_REG the second read follows the already-incremented Rn
  assign m_addr = same_q ? rn_q[27:0] + 28'd2 : rm_q[27:0];
  assign rd_n = state_q == RD_N;
  assign rd_m = state_q == RD_M;
  assign mac_wr = state_q == WB || state_q == WA;
  assign BUSY = state_q != IDLE;
  assign MEM_REQ = rd_n | (rd_m & ~m_addr[0]);
  assign MEM_A = rd_n ? rn_q[27:0] : (MEM_REQ ? m_addr : 28'd0);
  assign MEM_BA = !MEM_REQ ? 4'b0000 : (MEM_A[1] ? 4'b0011 : 4'b1100);
  // strobes are consumed on the CE_R edge, so a soft reset on that edge kills them
  assign RN_WE = rd_n & ~MEM_BUSY & RES_N;
  assign RN_NEW = rd_n ? rn_q + 32'd2 : 32'd0;
  assign RM_WE = rd_m & ~m_addr[0] & ~MEM_BUSY & RES_N;
  assign RM_NEW = !rd_m ? 32'd0 : (same_q ? rn_q + 32'd4 : rm_q + 32'd2);
  assign ADDR_ERR = RES_N & ((state_q == IDLE & START & RN_VAL[0]) | (rd_m & m_addr[0]));
  assign MAC_WE = mac_wr & RES_N;
  assign MAC_SEL = state_q == WB ? 2'b10 : (state_q == WA ? 2'b01 : 2'b00);
  assign MAC_OP = mac_wr ? 4'b1011 : 4'b0000;
  assign MAC_S = BUSY & s_q;
  assign MAC_A = mac_wr ? addr_q : 28'd0;
  assign MAC_DI = mac_wr ? dbuf_q : 32'd0;
  assign STALL = STS_REQ & (BUSY | post_q);
  always_comb begin
    state_d = state_q;
    rm_d = rm_q;
    rn_d = rn_q;
    s_d = s_q;
    same_d = same_q;
    dbuf_d = dbuf_q;
    addr_d = addr_q;
    post_d = 1'b0;
    if (!RES_N) state_d = IDLE;
    else if (state_q == IDLE && START) begin
      rm_d = RM_VAL;
      rn_d = RN_VAL;
      s_d = S_BIT;
      same_d = SAME_REG;
      state_d = RN_VAL[0] ? IDLE : RD_N;
    end else if (rd_n && !MEM_BUSY) begin
      dbuf_d = MEM_DI;
      addr_d = rn_q[27:0];
      state_d = WB;
    end else if (state_q == WB) state_d = RD_M;
    else if (rd_m && m_addr[0]) state_d = IDLE;
    else if (rd_m && !MEM_BUSY) begin
      dbuf_d = MEM_DI;
      addr_d = m_addr;
      state_d = WA;
    end else if (state_q == WA) begin
      post_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      rm_q <= '0;
      rn_q <= '0;
      s_q <= 1'b0;
      same_q <= 1'b0;
      dbuf_q <= '0;
      addr_q <= '0;
      post_q <= 1'b0;
    end else if (CE_R) begin
      state_q <= state_d;
      rm_q <= rm_d;
      rn_q <= rn_d;
      s_q <= s_d;
      same_q <= same_d;
      dbuf_q <= dbuf_d;
      addr_q <= addr_d;
      post_q <= post_d;
    end
endmodule

// File: tb/tb_sh7034_macw_seq.sv
// tb_sh7034_macw_seq: scoreboard bench; a reference model queues the expected bus/writeback/MAC
// events per instruction and a monitor compares what the DUT presents on each CE_R edge.
module tb_sh7034_macw_seq;
  logic CLK, RST_N, CE_R, CE_F, RES_N, START, S_BIT, SAME_REG, MEM_BUSY, STS_REQ;
  logic [31:0] RM_VAL, RN_VAL, MEM_DI, RM_NEW, RN_NEW, MAC_DI;
  logic [27:0] MEM_A, MAC_A;
  logic [3:0] MEM_BA, MAC_OP;
  logic [1:0] MAC_SEL;
  logic MEM_REQ, RM_WE, RN_WE, MAC_S, MAC_WE, BUSY, STALL, ADDR_ERR;
  typedef struct packed {logic [2:0] k; logic [31:0] v; logic [27:0] a; logic [3:0] x;} ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0, busy_left = 0, busy_pct = 0;
  bit ce_rand = 0;
  longint last_prod = 0;
  logic signed [15:0] mb_half;
  sh7034_macw_seq dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N), .START(START),
    .S_BIT(S_BIT), .SAME_REG(SAME_REG), .RM_VAL(RM_VAL), .RN_VAL(RN_VAL),
    .MEM_A(MEM_A), .MEM_BA(MEM_BA), .MEM_REQ(MEM_REQ), .MEM_DI(MEM_DI), .MEM_BUSY(MEM_BUSY),
    .RM_NEW(RM_NEW), .RM_WE(RM_WE), .RN_NEW(RN_NEW), .RN_WE(RN_WE),
    .MAC_SEL(MAC_SEL), .MAC_OP(MAC_OP), .MAC_S(MAC_S), .MAC_WE(MAC_WE), .MAC_A(MAC_A),
    .MAC_DI(MAC_DI), .BUSY(BUSY), .STS_REQ(STS_REQ), .STALL(STALL), .ADDR_ERR(ADDR_ERR)
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;
  function automatic logic [31:0] mem_word(input logic [27:0] a);
    if (a == 28'h100) return 32'h1234_ABCD;
    if (a == 28'h202) return 32'h7777_FFFE;
    return {a[15:0] ^ 16'h5A3C, ~a[15:0] ^ 16'h1357};
  endfunction
  always_comb MEM_DI = MEM_REQ ? mem_word(MEM_A) : 32'h0;
  function automatic logic [3:0] lanes(input logic [27:0] a);
    return a[1] ? 4'b0011 : 4'b1100;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic see(input ev_t o);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event: k=%0d v=%h a=%h x=%h", o.k, o.v, o.a, o.x);
    end else begin
      e = exp_q.pop_front();
      if (e !== o) begin
        errors++;
        $display("FAIL event: got k=%0d v=%h a=%h x=%h expected k=%0d v=%h a=%h x=%h",
                 o.k, o.v, o.a, o.x, e.k, e.v, e.a, e.x);
      end
    end
  endtask
  // one MAC.W as seen from outside: read Rn, post Rn+2, MB write, read Rm, post Rm, MA write
  task automatic push_op(input logic [31:0] rn, input logic [31:0] rm, input logic same, input logic s);
    logic [31:0] ma;
    if (rn[0]) begin
      exp_q.push_back(ev_t'{3'd5, 32'd0, 28'd0, 4'd0});
      return;
    end
    exp_q.push_back(ev_t'{3'd1, 32'd0, rn[27:0], lanes(rn[27:0])});
    exp_q.push_back(ev_t'{3'd2, rn + 32'd2, 28'd0, 4'd0});
    exp_q.push_back(ev_t'{3'd4, mem_word(rn[27:0]), rn[27:0], {2'b10, s, 1'b1}});
    ma = same ? rn + 32'd2 : rm;
    if (ma[0]) begin
      exp_q.push_back(ev_t'{3'd5, 32'd0, 28'd0, 4'd0});
      return;
    end
    exp_q.push_back(ev_t'{3'd1, 32'd0, ma[27:0], lanes(ma[27:0])});
    exp_q.push_back(ev_t'{3'd3, ma + 32'd2, 28'd0, 4'd0});
    exp_q.push_back(ev_t'{3'd4, mem_word(ma[27:0]), ma[27:0], {2'b01, s, 1'b1}});
  endtask
  always @(negedge CLK)
    if (RST_N && CE_R) begin
      if (MEM_REQ && !MEM_BUSY) see(ev_t'{3'd1, 32'd0, MEM_A, MEM_BA});
      if (RN_WE) see(ev_t'{3'd2, RN_NEW, 28'd0, 4'd0});
      if (RM_WE) see(ev_t'{3'd3, RM_NEW, 28'd0, 4'd0});
      if (MAC_WE) begin
        see(ev_t'{3'd4, MAC_DI, MAC_A, {MAC_SEL, MAC_S, MAC_OP == 4'b1011}});
        if (MAC_SEL == 2'b10) mb_half = MAC_A[1] ? MAC_DI[15:0] : MAC_DI[31:16];
        else last_prod = longint'(mb_half) * longint'($signed(MAC_A[1] ? MAC_DI[15:0] : MAC_DI[31:16]));
      end
      if (ADDR_ERR) see(ev_t'{3'd5, 32'd0, 28'd0, 4'd0});
    end
  task automatic tick();
    @(posedge CLK);
    #1;
    CE_R = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (busy_left > 0) begin
      MEM_BUSY = 1'b1;
      busy_left--;
    end else MEM_BUSY = ($urandom_range(0, 99) < busy_pct);
  endtask
  task automatic start_op(input logic [31:0] rn, input logic [31:0] rm, input logic same, input logic s);
    bit c;
    push_op(rn, rm, same, s);
    RN_VAL = rn;
    RM_VAL = rm;
    SAME_REG = same;
    S_BIT = s;
    START = 1'b1;
    do begin
      c = CE_R;
      tick();
    end while (!c);
    START = 1'b0;
    RN_VAL = $urandom;
    RM_VAL = $urandom;
  endtask
  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!BUSY && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(name, ok, 1'b1);
    if (!ok) exp_q.delete();
  endtask
  task automatic count_busy(output int n);
    n = 0;
    while (BUSY && n < 40) begin
      if (n < 4 && busy_left > 0) chk("wait hold MEM_A", {MEM_REQ, MEM_A}, {1'b1, 28'h100});
      tick();
      n++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic [31:0] rn, rm;
    RST_N = 0; CE_R = 1; CE_F = 0; RES_N = 1; START = 0; S_BIT = 1; SAME_REG = 0;
    RM_VAL = 32'h203; RN_VAL = 32'h100; MEM_BUSY = 0; STS_REQ = 1;
    #3;
    chk("reset mem", {MEM_A, MEM_BA, MEM_REQ}, 0);
    chk("reset wb", {RM_NEW, RM_WE, RN_NEW, RN_WE}, 0);
    chk("reset mac", {MAC_SEL, MAC_OP, MAC_S, MAC_WE, MAC_A, MAC_DI}, 0);
    chk("reset status", {BUSY, STALL, ADDR_ERR}, 0);
    @(posedge CLK); #1;
    RST_N = 1; STS_REQ = 0;
    tick();
    // basic sequence, five CE_R edges, product 0x1234 * -2
    start_op(32'h100, 32'h202, 0, 1);
    chk("basic busy after E0", BUSY, 1'b1);
    count_busy(n);
    chk("basic edges after E0", n, 4);
    wait_idle("basic done");
    chk("basic product", last_prod, -64'sd9320);
    // three wait states on the Rn read
    start_op(32'h100, 32'h202, 0, 0);
    MEM_BUSY = 1; busy_left = 2;
    count_busy(n);
    chk("wait edges after E0", n, 7);
    wait_idle("wait done");
    start_op(32'h400, 32'h400, 1, 1);
    wait_idle("same reg done");
    // odd Rn: error on the START edge, nothing issued
    start_op(32'h101, 32'h200, 0, 0);
    chk("odd rn idle", {BUSY, MEM_REQ, MAC_WE}, 0);
    wait_idle("odd rn done");
    start_op(32'h300, 32'h301, 0, 0);
    wait_idle("odd rm done");
    chk("odd rm idle", {BUSY, MAC_WE}, 0);
    // soft reset while presenting MB
    start_op(32'h800, 32'h900, 0, 0);
    tick();
    RES_N = 0;
    tick();
    chk("softrst idle", {BUSY, MAC_WE}, 0);
    chk("softrst pending events", exp_q.size(), 4);
    exp_q.delete();
    RES_N = 1;
    wait_idle("softrst done");
    // START on the E4 edge must be ignored
    start_op(32'h500, 32'h600, 0, 0);
    repeat (3) tick();
    RN_VAL = 32'h700; START = 1;
    tick();
    START = 0;
    chk("start at E4 ignored", BUSY, 1'b0);
    wait_idle("E4 done");
    // STS interlock from E2 through one CE_R past E4
    start_op(32'hA00, 32'hB02, 0, 1);
    tick();
    STS_REQ = 1;
    tick();
    chk("stall E2", STALL, 1'b1);
    tick();
    chk("stall E3", STALL, 1'b1);
    tick();
    chk("stall E4", {BUSY, STALL}, 2'b01);
    tick();
    chk("stall E5", STALL, 1'b0);
    STS_REQ = 0;
    wait_idle("stall done");
    // random traffic with gated CE_R and wait states
    ce_rand = 1; busy_pct = 30;
    for (int i = 0; i < 60; i++) begin
      rn = $urandom;
      rm = $urandom;
      rn[0] = ($urandom_range(0, 7) == 0);
      rm[0] = ($urandom_range(0, 7) == 0);
      if (i % 10 == 0) rn[31:2] = '1;
      start_op(rn, rm, $urandom_range(0, 3) == 0, 1'($urandom));
      wait_idle("random done");
    end
    repeat (5) tick();
    chk("queue drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
